// File: rtl/tetris_pkg.sv
// tetris_pkg: board geometry, score width and the line-clear FSM encoding
// shared by the line-clear stage and its neighbours.
package tetris_pkg;
    localparam int ROWS    = 20;
    localparam int COLS    = 10;
    localparam int BOARD_W = ROWS * COLS;
    localparam int SCORE_W = 64;

    typedef enum logic [2:0] {
        LC_IDLE,
        LC_SCAN,
        LC_REQ,
        LC_WAIT,
        LC_FIN
    } lc_state_e;
endpackage

// File: rtl/line_clear_stage.sv
// line_clear_stage: removes full rows from a placed board one row per cycle,
// then asks the analysis stage for a score and reports it with a done pulse.
module line_clear_stage #(
    parameter int ROWS    = 20,
    parameter int COLS    = 10,
    parameter int TIMEOUT = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [ROWS*COLS-1:0]                  board_in,
    output logic                                  busy,
    output logic [ROWS*COLS-1:0]                  board_out,
    output logic [9:0]                            cleared_lines,
    output logic                                  req_score,
    input  logic                                  recv_score,
    input  logic signed [tetris_pkg::SCORE_W-1:0] score,
    output logic signed [tetris_pkg::SCORE_W-1:0] result_score,
    output logic                                  done,
    output logic                                  timeout_err
);
    import tetris_pkg::*;

    localparam int PW = $clog2(ROWS);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic signed [SCORE_W-1:0] WORST = {1'b0, {(SCORE_W-1){1'b1}}};

    lc_state_e                 state_q, state_d;
    logic [ROWS-1:0][COLS-1:0] board_q, board_d, shifted;
    logic [9:0]                cl_q, cl_d;
    logic [PW-1:0]             ptr_q, ptr_d;
    logic [WW-1:0]             wcnt_q, wcnt_d;
    logic signed [SCORE_W-1:0] res_q, res_d;
    logic                      terr_q, terr_d;

    // Rows above the pointer drop by one; a blank row enters at the top.
    always_comb begin
        shifted[0] = '0;
        for (int r = 1; r < ROWS; r++)
            shifted[r] = (PW'(r) > ptr_q) ? board_q[r] : board_q[r-1];
    end

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        cl_d    = cl_q;
        ptr_d   = ptr_q;
        wcnt_d  = wcnt_q;
        res_d   = res_q;
        terr_d  = terr_q;
        case (state_q)
            LC_IDLE: if (start) begin
                state_d = LC_SCAN;
                board_d = board_in;
                cl_d    = '0;
                terr_d  = 1'b0;
                ptr_d   = PW'(ROWS - 1);
            end
            LC_SCAN: if (&board_q[ptr_q]) begin
                board_d = shifted;
                cl_d    = cl_q + 1'b1;
            end else if (ptr_q == '0) begin
                state_d = LC_REQ;
            end else begin
                ptr_d = ptr_q - 1'b1;
            end
            LC_REQ: begin
                state_d = LC_WAIT;
                wcnt_d  = '0;
            end
            LC_WAIT: begin
                wcnt_d = wcnt_q + 1'b1;
                // A score arriving on the final wait cycle still wins over the timeout.
                if (recv_score) begin
                    res_d   = score;
                    state_d = LC_FIN;
                end else if (wcnt_d == WW'(TIMEOUT)) begin
                    res_d   = WORST;
                    terr_d  = 1'b1;
                    state_d = LC_FIN;
                end
            end
            LC_FIN:  state_d = LC_IDLE;
            default: state_d = LC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LC_IDLE;
            board_q <= '0;
            cl_q    <= '0;
            ptr_q   <= '0;
            wcnt_q  <= '0;
            res_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            cl_q    <= cl_d;
            ptr_q   <= ptr_d;
            wcnt_q  <= wcnt_d;
            res_q   <= res_d;
            terr_q  <= terr_d;
        end
    end

    assign busy          = state_q != LC_IDLE;
    assign req_score     = state_q == LC_REQ;
    assign done          = state_q == LC_FIN;
    assign board_out     = board_q;
    assign cleared_lines = cl_q;
    assign result_score  = res_q;
    assign timeout_err   = terr_q;
endmodule

// File: tb/tb_line_clear_stage.sv
// tb_line_clear_stage: random and directed boards against a row-compaction
// model, with a responding analysis stage and mid-operation resets.
module tb_line_clear_stage;
    import tetris_pkg::*;

    localparam int TIMEOUT = 16;
    localparam logic signed [63:0] WORST = 64'sh7FFF_FFFF_FFFF_FFFF;

    logic                      clk = 1'b0, rst_n = 1'b1, start = 1'b0, recv_score = 1'b0;
    logic [BOARD_W-1:0]        board_in = '0;
    logic signed [63:0]        score = '0;
    logic                      busy, req_score, done, timeout_err;
    logic [BOARD_W-1:0]        board_out;
    logic [9:0]                cleared_lines;
    logic signed [63:0]        result_score;
    int                        n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    line_clear_stage #(.ROWS(ROWS), .COLS(COLS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .board_in(board_in), .busy(busy),
        .board_out(board_out), .cleared_lines(cleared_lines), .req_score(req_score),
        .recv_score(recv_score), .score(score), .result_score(result_score),
        .done(done), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [BOARD_W-1:0] act, input logic [BOARD_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_board"}, board_out, '0);
        check({tag, "_ctl"}, {busy, req_score, done, timeout_err, cleared_lines, result_score}, '0);
    endtask

    // Full rows vanish; the survivors keep their order and settle at the bottom.
    function automatic void compact(input logic [BOARD_W-1:0] b, output logic [BOARD_W-1:0] o, output int cl);
        int dst = ROWS - 1;
        o  = '0;
        cl = 0;
        for (int r = ROWS - 1; r >= 0; r--)
            if (b[r*COLS +: COLS] == {COLS{1'b1}}) cl++;
            else begin
                o[dst*COLS +: COLS] = b[r*COLS +: COLS];
                dst--;
            end
    endfunction

    // d = cycles from req to recv (0 = analysis stage never answers).
    task automatic run(input logic [BOARD_W-1:0] b, input int d, input logic signed [63:0] sc, input bit noise);
        logic [BOARD_W-1:0] eb;
        int ecl, k, rq, dn, nreq, edn;
        bit to, bsy1, bsyd, unstable;
        compact(b, eb, ecl);
        to  = (d == 0 || d > TIMEOUT);
        edn = ROWS + ecl + 2 + (to ? TIMEOUT : d);
        @(negedge clk);
        start = 1'b1;
        board_in = b;
        rq = -1; dn = -1; nreq = 0; k = 0;
        bsy1 = 1'b0; bsyd = 1'b0; unstable = 1'b0;
        while (dn < 0 && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) bsy1 = busy;
            if (req_score) begin
                nreq++;
                if (rq < 0) rq = k;
            end
            if (rq >= 0 && (board_out !== eb || cleared_lines !== 10'(ecl))) unstable = 1'b1;
            if (done) begin
                dn = k;
                bsyd = busy;
            end
            start = noise && k == 5;
            if (start) board_in = ~b;
            recv_score = (noise && k == 3) || (rq >= 0 && d > 0 && k == rq + d);
            score = (noise && k == 3) ? 64'sh0BAD_0BAD_0BAD_0BAD : sc;
        end
        check("busy_first", bsy1, 1'b1);
        check("req_cycle", rq, ROWS + ecl + 1);
        check("req_pulses", nreq, 1);
        check("done_cycle", dn, edn);
        check("busy_at_done", bsyd, 1'b1);
        check("out_stable", unstable, 1'b0);
        check("cleared", cleared_lines, 10'(ecl));
        check("board", board_out, eb);
        check("result", result_score, to ? WORST : sc);
        check("timeout_err", timeout_err, to);
        @(negedge clk);
        recv_score = 1'b0;
        start = 1'b0;
        check("idle_hold", {busy, done, req_score, timeout_err, result_score, cleared_lines},
              {3'b000, to, to ? WORST : sc, 10'(ecl)});
        check("idle_board", board_out, eb);
    endtask

    task automatic reset_mid(input logic [BOARD_W-1:0] b, input int cyc);
        @(negedge clk);
        start = 1'b1;
        board_in = b;
        @(negedge clk);
        start = 1'b0;
        repeat (cyc - 1) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        recv_score = 1'b1;
        score = 64'sd12345;
        @(negedge clk);
        recv_score = 1'b0;
        check_zero("rst_recv");
    endtask

    initial begin
        logic [BOARD_W-1:0] b44, b45, rb;
        int d, sel;
        b44 = '0;
        b44[19*COLS +: COLS] = '1;
        b44[18*COLS +: COLS] = '1;
        b44[17*COLS +: COLS] = 10'b0000000001;
        b45 = '0;
        b45[19*COLS +: COLS] = '1;
        b45[18*COLS +: COLS] = 10'h155;
        b45[17*COLS +: COLS] = '1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("por");
        rst_n = 1'b1;
        run('0, 2, 64'sd100, 1'b0);
        run(b44, 2, -64'sd7, 1'b0);
        run(b45, 2, 64'sd42, 1'b0);
        run('1, 2, -64'sd1, 1'b0);
        run(b44, 0, 64'sd5, 1'b0);
        run(b45, TIMEOUT, 64'sd77, 1'b0);
        run('0, TIMEOUT + 1, 64'sd88, 1'b0);
        reset_mid(b44, 8);
        run(b45, 2, 64'sd3, 1'b1);
        reset_mid('0, 25);
        run(b44, 1, 64'sd9, 1'b1);
        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < ROWS; r++)
                rb[r*COLS +: COLS] = ($urandom_range(0, 2) == 0) ? {COLS{1'b1}} : COLS'($urandom);
            sel = $urandom_range(0, 9);
            d = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(TIMEOUT + 1, TIMEOUT + 4) : $urandom_range(1, TIMEOUT);
            run(rb, d, {$urandom, $urandom}, 1'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
